// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/flush controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        IRQ_ARM  = 2'd1,
        IRQ_TAKE = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int CNT_W_DEF     = 32;
    localparam int IRQ_CNT_W_DEF = 16;

endpackage

// File: rtl/hazard_load_use_detect.sv
// Combinational load-use detector: the EX load targets a register the ID instruction reads.
module hazard_load_use_detect
    import hazard_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       ex_memrd,
    input  logic [4:0] ex_rt,
    output logic       load_use
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit   = id_uses_rs && (id_rs == ex_rt);
    assign rt_hit   = id_uses_rt && (id_rt == ex_rt);
    // A load into $zero never produces a value, so it can never stall.
    assign load_use = ex_memrd && (ex_rt != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Hazard and flush controller for the five-stage datapath: load-use stalls, branch/jump
// flushes and interrupt entry. Define HAZARD_PERF_CNT_EN to build the performance counters.
module hazard_flush_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int IRQ_CNT_W = IRQ_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           id_rs,
    input  logic [4:0]           id_rt,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic                 id_jump,
    input  logic                 id_branch,
    input  logic                 id_kernel,
    input  logic                 ex_memrd,
    input  logic [4:0]           ex_rt,
    input  logic                 ex_branch_taken,
    input  logic                 irq,
    output logic                 pc_write,
    output logic                 ifid_write,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 irq_take,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt,
    output logic [IRQ_CNT_W-1:0] irq_cnt,
    output logic [1:0]           state_dbg
);

    hz_state_t state;
    hz_state_t state_nxt;
    logic      irq_pending;
    logic      load_use;
    logic      hz_active;
    logic      clean_window;
    logic      do_stall;
    logic      ctrl_flush;

    hazard_load_use_detect u_lu (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .ex_memrd   (ex_memrd),
        .ex_rt      (ex_rt),
        .load_use   (load_use)
    );

    assign hz_active    = (state == RUN) || (state == IRQ_ARM);
    assign clean_window = !ex_branch_taken && !load_use && !id_jump && !id_branch && !id_kernel;
    assign do_stall     = hz_active && load_use && !ex_branch_taken;
    assign ctrl_flush   = (hz_active && (ex_branch_taken || (id_jump && !load_use)))
                        || (state == IRQ_TAKE);
    assign state_dbg    = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Clearing on the TAKE exit wins over a same-edge set from a still-high irq.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_pending <= 1'b0;
        end else if (state == IRQ_TAKE) begin
            irq_pending <= 1'b0;
        end else if (irq && !id_kernel) begin
            irq_pending <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      if (irq_pending) state_nxt = IRQ_ARM;
            IRQ_ARM:  if (clean_window) state_nxt = IRQ_TAKE;
            IRQ_TAKE: state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        irq_take   = 1'b0;
        case (state)
            RUN, IRQ_ARM: begin
                if (ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end else if (id_jump) begin
                    ifid_flush = 1'b1;
                end
            end
            IRQ_TAKE: begin
                irq_take   = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0]     stall_cnt_q;
    logic [CNT_W-1:0]     flush_cnt_q;
    logic [IRQ_CNT_W-1:0] irq_cnt_q;

    // All counters hold at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            irq_cnt_q   <= '0;
        end else begin
            if (do_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (ctrl_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            if ((state == IRQ_TAKE) && (irq_cnt_q != '1)) irq_cnt_q <= irq_cnt_q + IRQ_CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign irq_cnt   = irq_cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt = do_stall ^ ctrl_flush;
    assign stall_cnt  = '0;
    assign flush_cnt  = '0;
    assign irq_cnt    = '0;
`endif

endmodule
